flu_qdr_wr: RTL
===============

FLU_QDR_WR -- requirements
Module: flu_qdr_wr

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 512, meaning the FLU data width in bits.
REQ-002 The block SHALL have parameter SOP_POS_WIDTH, default 3, meaning the SOP position width (block granularity).
REQ-003 The block SHALL have parameter EOP_POS_WIDTH, default 6, meaning the EOP position width (byte granularity).
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 20, meaning the QDR ring-buffer address width (depth 2^ADDR_WIDTH words).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset: APP_CLK in 1, clock (all logic on rising edge).
REQ-006 APP_RST  in  1  synchronous active-high reset.
REQ-007 RX_DATA  in  DATA_WIDTH  FLU data word.
REQ-008 RX_SOP_POS  in  SOP_POS_WIDTH  SOP block position; RX_EOP_POS  in  EOP_POS_WIDTH  EOP byte position.
REQ-009 RX_SOP  in  1; RX_EOP  in  1; RX_SRC_RDY  in  1; RX_DST_RDY  out  1  FLU handshake, transfer when SRC_RDY and DST_RDY are both 1.
REQ-010 QDR_WR_ADDR  out  ADDR_WIDTH  write address.
REQ-011 QDR_WR_DATA  out  DATA_WIDTH+SOP_POS_WIDTH+EOP_POS_WIDTH+2  packed word {EOP, SOP, EOP_POS, SOP_POS, DATA}, MSB first.
REQ-012 QDR_WR_VLD  out  1; QDR_WR_RDY  in  1  write handshake, transfer when both are 1.
REQ-013 RD_PTR  in  ADDR_WIDTH  next address the read side will read, already in the APP_CLK domain.
REQ-014 WR_PTR  out  ADDR_WIDTH  committed write pointer (first address not yet released to the reader).
REQ-015 PROTO_ERR  out  1  sticky FLU protocol violation flag.

Function
REQ-016 The block SHALL hold an internal address counter WA, the address of the next word to issue.
REQ-017 Occupancy SHALL be (WA - RD_PTR) mod 2^ADDR_WIDTH, and FULL SHALL be occupancy = 2^ADDR_WIDTH-1.
REQ-018 RX_DST_RDY SHALL equal (not APP_RST) and (not FULL) and ((not QDR_WR_VLD) or QDR_WR_RDY), combinationally.
REQ-019 An accepted word that is not discarded SHALL appear on QDR_WR_* one cycle later, so latency is 1, with QDR_WR_ADDR=WA; WA SHALL then increment, wrapping 2^ADDR_WIDTH-1 -> 0.
REQ-020 QDR_WR_VLD/ADDR/DATA SHALL hold stable while QDR_WR_VLD=1 and QDR_WR_RDY=0.
REQ-021 QDR_WR_VLD SHALL clear after a handshake when no new word is accepted in the same cycle.
REQ-022 The frame FSM SHALL have states IDLE (outside a frame) and FRAME; a "single" word is SOP=EOP=1 with EOP_POS >= SOP_POS*64/8 bytes.
REQ-023 In IDLE, accepted SOP without EOP SHALL go to FRAME; a single word SHALL stay in IDLE; SOP=EOP=1 that is not single SHALL go to FRAME.
REQ-024 In IDLE, an accepted word with SOP=0 SHALL be discarded (not written, WA unchanged) and SHALL set PROTO_ERR.
REQ-025 In FRAME, EOP with SOP=0 SHALL go to IDLE; EOP with SOP=1 where the new SOP follows the EOP SHALL stay in FRAME.
REQ-026 In FRAME, SOP without EOP, or SOP=EOP=1 with SOP before the EOP, SHALL set PROTO_ERR; the word SHALL be written and the state SHALL stay FRAME.
REQ-027 On the QDR handshake of a word whose EOP terminates a frame, WR_PTR SHALL become that word's address+1 (mod depth) on the next cycle; it SHALL not change otherwise.
REQ-028 Simultaneous QDR handshake and RX acceptance SHALL sustain one word per cycle.
REQ-029 A frame of 2^ADDR_WIDTH-1 or more words SHALL stall RX at FULL indefinitely; this is a documented restriction, with no drop.
REQ-030 RD_PTR changes SHALL affect FULL and RX_DST_RDY in the same cycle.

Reset
REQ-031 While APP_RST=1: WA=0, WR_PTR=0, QDR_WR_VLD=0, QDR_WR_ADDR=0, QDR_WR_DATA=0, PROTO_ERR=0, FSM=IDLE, and RX_DST_RDY=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame: uncommitted words are lost, WR_PTR=0, and the read side is reset with the block.

Verification
REQ-033 3-word frame (SOP_POS=0, EOP_POS=63), QDR_WR_RDY=1, RD_PTR=0 -> addresses 0,1,2 on consecutive cycles, latency 1, WR_PTR=3 one cycle after the third handshake.
REQ-034 ADDR_WIDTH=4, RD_PTR=0, stream 20 words in 1-word frames -> RX_DST_RDY=0 after 15 writes; with RD_PTR=5, writing resumes, WA wraps 15->0, and WR_PTR tracks through the wrap.
REQ-035 QDR_WR_RDY held 0 for 4 cycles with the output valid -> QDR_WR_ADDR/DATA stable, RX_DST_RDY=0, no word lost or duplicated.
REQ-036 Word with SOP=0 in IDLE -> not written, WA unchanged, PROTO_ERR=1 and sticky until APP_RST.
REQ-037 In FRAME, word SOP=EOP=1 with EOP_POS=10 and SOP_POS=2 -> first frame is committed, FSM stays FRAME, and the next word with EOP=1 commits again.
REQ-038 APP_RST pulsed after 2 words of a frame -> all outputs return to reset values next cycle, and a new frame starts at address 0.

Source files
------------

// File: rtl/flu_qdr_wr.sv
// FLU-to-QDR write side: packs FLU words into ring-buffer writes and tracks frames.
// WR_PTR only advances past words whose EOP closes a frame, so the reader sees whole frames.
module flu_qdr_wr #(
    parameter int DATA_WIDTH    = 512,
    parameter int SOP_POS_WIDTH = 3,
    parameter int EOP_POS_WIDTH = 6,
    parameter int ADDR_WIDTH    = 20
) (
    input  logic                                                   APP_CLK,
    input  logic                                                   APP_RST,
    input  logic [DATA_WIDTH-1:0]                                  RX_DATA,
    input  logic [SOP_POS_WIDTH-1:0]                               RX_SOP_POS,
    input  logic [EOP_POS_WIDTH-1:0]                               RX_EOP_POS,
    input  logic                                                   RX_SOP,
    input  logic                                                   RX_EOP,
    input  logic                                                   RX_SRC_RDY,
    output logic                                                   RX_DST_RDY,
    output logic [ADDR_WIDTH-1:0]                                  QDR_WR_ADDR,
    output logic [DATA_WIDTH+SOP_POS_WIDTH+EOP_POS_WIDTH+2-1:0]    QDR_WR_DATA,
    output logic                                                   QDR_WR_VLD,
    input  logic                                                   QDR_WR_RDY,
    input  logic [ADDR_WIDTH-1:0]                                  RD_PTR,
    output logic [ADDR_WIDTH-1:0]                                  WR_PTR,
    output logic                                                   PROTO_ERR
);

    localparam int PW = (SOP_POS_WIDTH + 3 > EOP_POS_WIDTH) ? SOP_POS_WIDTH + 3 : EOP_POS_WIDTH;

    typedef enum logic {IDLE, FRAME} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] wa;
    logic [ADDR_WIDTH-1:0] occupancy;
    logic                  full;
    logic                  accept;
    logic                  single;
    logic                  discard;
    logic                  term;
    logic                  err;
    logic                  term_q;
    logic [PW-1:0]         sop_byte;
    logic [PW-1:0]         eop_byte;

    assign occupancy  = wa - RD_PTR;
    assign full       = (occupancy == '1);
    assign RX_DST_RDY = !APP_RST && !full && (!QDR_WR_VLD || QDR_WR_RDY);
    assign accept     = RX_SRC_RDY && RX_DST_RDY;

    // SOP position is in 8-byte blocks; EOP position is in bytes.
    assign sop_byte = PW'({RX_SOP_POS, 3'b000});
    assign eop_byte = PW'(RX_EOP_POS);
    assign single   = RX_SOP && RX_EOP && (eop_byte >= sop_byte);

    always_comb begin
        state_nxt = state;
        discard   = 1'b0;
        term      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (!RX_SOP) begin
                    discard = 1'b1;
                    err     = 1'b1;
                end else if (single) begin
                    term = 1'b1;
                end else begin
                    state_nxt = FRAME;
                end
            end
            FRAME: begin
                if (RX_EOP && !RX_SOP) begin
                    term      = 1'b1;
                    state_nxt = IDLE;
                end else if (RX_SOP && RX_EOP && !single) begin
                    // old frame ends in this word and a new one starts after it
                    term = 1'b1;
                end else if (RX_SOP) begin
                    err = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge APP_CLK) begin
        if (APP_RST) begin
            state       <= IDLE;
            wa          <= '0;
            WR_PTR      <= '0;
            QDR_WR_VLD  <= 1'b0;
            QDR_WR_ADDR <= '0;
            QDR_WR_DATA <= '0;
            PROTO_ERR   <= 1'b0;
            term_q      <= 1'b0;
        end else begin
            if (QDR_WR_VLD && QDR_WR_RDY && term_q)
                WR_PTR <= QDR_WR_ADDR + ADDR_WIDTH'(1);

            if (accept && !discard) begin
                QDR_WR_VLD  <= 1'b1;
                QDR_WR_ADDR <= wa;
                QDR_WR_DATA <= {RX_EOP, RX_SOP, RX_EOP_POS, RX_SOP_POS, RX_DATA};
                term_q      <= term;
                wa          <= wa + ADDR_WIDTH'(1);
            end else if (QDR_WR_VLD && QDR_WR_RDY) begin
                QDR_WR_VLD <= 1'b0;
            end

            if (accept) begin
                state <= state_nxt;
                if (err)
                    PROTO_ERR <= 1'b1;
            end
        end
    end

endmodule
